// File: rtl/if_fetch_unit_if.sv
// Instruction bus bundle for the fetch stage.
// Carries the req/gnt/rvalid read handshake.
interface if_fetch_unit_if;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word reads,
// buffers responses in a small prefetch FIFO and feeds IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2,
  parameter logic [31:0] INST_NOP_VAL = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic [2:0]            hold_flag_i,
  if_fetch_unit_if.master       ibus,
  output logic [31:0]           inst_o,
  output logic [31:0]           inst_addr_o,
  output logic                  inst_valid_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_twp;
  logic [AW-1:0] r_trp;

  logic [31:0]   r_data [FIFO_DEPTH];
  logic [31:0]   r_addr [FIFO_DEPTH];
  logic [31:0]   r_tag  [FIFO_DEPTH];

  logic [SW-1:0] w_busy;
  logic          w_req;
  logic          w_grant;
  logic          w_inflight;
  logic          w_rv;
  logic          w_rv_drop;
  logic          w_rv_live;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_jump_pc;
  logic [31:0]   w_tag_addr;

  // Credits: squashed reads still occupy a slot until they return
  assign w_busy = SW'(r_out) + SW'(r_drop) + SW'(r_cnt);

  assign w_req   = !rst && !jump_flag_i
                && (w_busy < SW'(FIFO_DEPTH));
  assign w_grant = w_req && ibus.ibus_gnt_i;

  // Stray responses with nothing in flight are ignored
  assign w_inflight = (r_out != '0) || (r_drop != '0);
  assign w_rv       = ibus.ibus_rvalid_i && w_inflight;
  assign w_rv_drop  = w_rv && (r_drop != '0);
  assign w_rv_live  = w_rv && (r_drop == '0);

  assign w_push = w_rv_live && !jump_flag_i;
  assign w_pop  = !rst && !jump_flag_i
               && (hold_flag_i == 3'd0)
               && (r_cnt != '0);

  assign w_jump_pc  = jump_addr_i & ~32'h3;
  assign w_tag_addr = r_tag[r_trp];

  assign ibus.ibus_req_o  = w_req;
  assign ibus.ibus_addr_o = r_pc;

  // Head of FIFO goes straight out; anything else is a bubble
  assign inst_o       = w_pop ? r_data[r_rp] : INST_NOP_VAL;
  assign inst_addr_o  = w_pop ? r_addr[r_rp] : 32'h0;
  assign inst_valid_o = w_pop;

  // PC, counters and pointers; jump flushes and converts in-flight to drops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_twp  <= '0;
      r_trp  <= '0;
    end else if (jump_flag_i) begin
      r_pc   <= w_jump_pc;
      r_drop <= r_drop + r_out - CW'(w_rv);
      r_out  <= '0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_twp  <= '0;
      r_trp  <= '0;
    end else begin
      if (w_grant) begin
        r_pc  <= r_pc + 32'd4;
        r_twp <= r_twp + AW'(1);
      end
      if (w_rv_live) begin
        r_trp <= r_trp + AW'(1);
      end
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_out  <= r_out + CW'(w_grant) - CW'(w_rv_live);
      r_drop <= r_drop - CW'(w_rv_drop);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage: issued-address tags and returned instruction entries
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag[r_twp] <= r_pc;
    end
    if (w_push) begin
      r_data[r_wp] <= ibus.ibus_rdata_i;
      r_addr[r_wp] <= w_tag_addr;
    end
  end

endmodule
